// File: rtl/alu_pkg.sv
// ============================================================================
//  Module     : alu_pkg
//  Description: Shared definitions for the EX-stage ALU and the divide
//               sequencer: ALU op-select encodings, RV32M divide op enum and
//               the divide sequencer FSM state enum.
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // ALU op-select encodings (match the ALU's i_alu_op decode)
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b0110;

    // RV32M divide/remainder selection; bit 0 = unsigned, bit 1 = remainder
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_NEG_A = 3'd1,
        S_NEG_B = 3'd2,
        S_CMP   = 3'd3,
        S_SUB   = 3'd4,
        S_FIX   = 3'd5,
        S_DONE  = 3'd6
    } div_state_e;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_div_sequencer.sv
// ============================================================================
//  Module     : alu_div_sequencer
//  Description: Multi-cycle restoring divider for DIV/DIVU/REM/REMU that
//               borrows the shared EX-stage ALU for every arithmetic step.
//               Signed operands are converted to magnitudes first, 32
//               compare/subtract iteration pairs follow, then the selected
//               result is sign-corrected.
//  Ports      : i_clk, i_reset           - clock, synchronous active-high reset
//               i_valid/o_ready          - request handshake (ready only in IDLE)
//               i_div_op, i_dividend,
//               i_divisor                - request payload
//               o_valid/i_ready, o_data  - result handshake and value
//               o_busy                   - high whenever not IDLE
//               o_alu_op_a/b, o_alu_op   - drive to the shared ALU
//               i_alu_data               - combinational ALU result
//  Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_div_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_div_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_data,
    output logic            o_busy,
    output logic [XLEN-1:0] o_alu_op_a,
    output logic [XLEN-1:0] o_alu_op_b,
    output logic [3:0]      o_alu_op,
    input  logic [XLEN-1:0] i_alu_data
);

    localparam logic [XLEN-1:0] c_int_min = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      r_state, w_state_next;
    div_op_e         r_op;
    logic [XLEN-1:0] r_dvd;     // dividend magnitude, shifts into quotient
    logic [XLEN-1:0] r_dsr;     // divisor magnitude
    logic [XLEN-1:0] r_rem;     // partial remainder
    logic            r_lt;      // rem_sh < dsr from the preceding CMP
    logic [4:0]      r_cnt;
    logic            r_sign_a;
    logic            r_sign_b;

    div_op_e         w_req_op;
    logic            w_req_signed;
    logic            w_req_rem;
    logic            w_accept;
    logic            w_div_zero;
    logic            w_signed_ovf;
    logic [XLEN-1:0] w_rem_sh;
    logic            w_ovf;
    logic            w_take;
    logic            w_is_rem;
    logic            w_neg;
    logic [XLEN-1:0] w_sel;

    assign w_req_op     = div_op_e'(i_div_op);
    assign w_req_signed = (w_req_op == DIV) || (w_req_op == REM);
    assign w_req_rem    = (w_req_op == REM) || (w_req_op == REMU);
    assign w_accept     = i_valid && (r_state == S_IDLE);
    assign w_div_zero   = (i_divisor == '0);
    assign w_signed_ovf = w_req_signed && (i_dividend == c_int_min) && (i_divisor == '1);

    // The remainder is conceptually 33 bits after the shift; the bit that
    // falls off the top (w_ovf) forces a subtract since rem_sh then exceeds
    // any 32-bit divisor, and the modulo-2^32 ALU difference is still exact.
    assign w_rem_sh = {r_rem[XLEN-2:0], r_dvd[XLEN-1]};
    assign w_ovf    = r_rem[XLEN-1];
    assign w_take   = w_ovf | ~r_lt;

    assign w_is_rem = (r_op == REM) || (r_op == REMU);
    assign w_sel    = w_is_rem ? r_rem : r_dvd;
    // Sign registers are zero for unsigned ops, so no op check is needed here
    assign w_neg    = w_is_rem ? r_sign_a : (r_sign_a ^ r_sign_b);

    assign o_ready = (r_state == S_IDLE);
    assign o_busy  = (r_state != S_IDLE);
    assign o_valid = (r_state == S_DONE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_alu_op     = ALU_ADD;
        o_alu_op_a   = '0;
        o_alu_op_b   = '0;
        case (r_state)
            S_IDLE: begin
                if (i_valid) begin
                    w_state_next = (w_div_zero || w_signed_ovf) ? S_DONE : S_NEG_A;
                end
            end
            S_NEG_A: begin
                o_alu_op     = ALU_SUB;
                o_alu_op_b   = r_dvd;
                w_state_next = S_NEG_B;
            end
            S_NEG_B: begin
                o_alu_op     = ALU_SUB;
                o_alu_op_b   = r_dsr;
                w_state_next = S_CMP;
            end
            S_CMP: begin
                o_alu_op     = ALU_SLTU;
                o_alu_op_a   = w_rem_sh;
                o_alu_op_b   = r_dsr;
                w_state_next = S_SUB;
            end
            S_SUB: begin
                o_alu_op     = ALU_SUB;
                o_alu_op_a   = w_rem_sh;
                o_alu_op_b   = r_dsr;
                w_state_next = (r_cnt == 5'd31) ? S_FIX : S_CMP;
            end
            S_FIX: begin
                o_alu_op     = ALU_SUB;
                o_alu_op_b   = w_sel;
                w_state_next = S_DONE;
            end
            S_DONE: begin
                if (i_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_op     <= DIV;
            r_dvd    <= '0;
            r_dsr    <= '0;
            r_rem    <= '0;
            r_lt     <= 1'b0;
            r_cnt    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            o_data   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op     <= w_req_op;
                        r_dvd    <= i_dividend;
                        r_dsr    <= i_divisor;
                        r_sign_a <= w_req_signed & i_dividend[XLEN-1];
                        r_sign_b <= w_req_signed & i_divisor[XLEN-1];
                        if (w_div_zero) begin
                            o_data <= w_req_rem ? i_dividend : '1;
                        end else if (w_signed_ovf) begin
                            o_data <= w_req_rem ? '0 : c_int_min;
                        end
                    end
                end
                S_NEG_A: begin
                    r_dvd <= r_sign_a ? i_alu_data : r_dvd;
                    r_rem <= '0;
                    r_cnt <= '0;
                end
                S_NEG_B: begin
                    r_dsr <= r_sign_b ? i_alu_data : r_dsr;
                end
                S_CMP: begin
                    r_lt <= i_alu_data[0];
                end
                S_SUB: begin
                    r_rem <= w_take ? i_alu_data : w_rem_sh;
                    r_dvd <= {r_dvd[XLEN-2:0], w_take};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_FIX: begin
                    o_data <= w_neg ? i_alu_data : w_sel;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : alu_div_sequencer

`default_nettype wire
